// File: rtl/write_seq.sv
// Sequential RAM writer: fills NUM_WORDS words with an arithmetic sequence, then flags completion.
// Define WRITE_SEQ_READBACK_EN to add a readback pass that verifies every word and sets a sticky error.
module write_seq #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned NUM_WORDS  = 4,
    parameter int unsigned INIT_VALUE = 0,
    parameter int unsigned STEP       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              valid,
    output logic              error,
    output logic [ADDR_W-1:0] waddr_0,
    output logic [DATA_W-1:0] wdata_0,
    output logic              wen_0,
    output logic [ADDR_W-1:0] raddr_0,
    input  logic [DATA_W-1:0] rdata_0
);

    localparam int unsigned CNT_W    = ADDR_W + 1;
    localparam int unsigned LAST_IDX = (NUM_WORDS > 0) ? NUM_WORDS - 1 : 0;
    localparam logic [CNT_W-1:0]  LAST = CNT_W'(LAST_IDX);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [DATA_W-1:0] INIT = DATA_W'(INIT_VALUE);
    localparam logic [DATA_W-1:0] INCR = DATA_W'(STEP);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
`ifdef WRITE_SEQ_READBACK_EN
        READ  = 3'd2,
        CHECK = 3'd3,
`endif
        DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic              valid_q, valid_d;

`ifdef WRITE_SEQ_READBACK_EN
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [DATA_W-1:0] rexp_q, rexp_d;
    logic              cmp_en_q, cmp_en_d;
    logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
    logic              error_q, error_d;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            valid_q   <= 1'b0;
`ifdef WRITE_SEQ_READBACK_EN
            raddr_q   <= '0;
            rexp_q    <= '0;
            cmp_en_q  <= 1'b0;
            cmp_exp_q <= '0;
            error_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            valid_q   <= valid_d;
`ifdef WRITE_SEQ_READBACK_EN
            raddr_q   <= raddr_d;
            rexp_q    <= rexp_d;
            cmp_en_q  <= cmp_en_d;
            cmp_exp_q <= cmp_exp_d;
            error_q   <= error_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        valid_d = valid_q;
`ifdef WRITE_SEQ_READBACK_EN
        raddr_d = raddr_q;
        rexp_d  = rexp_q;
        // rdata_0 answers the address presented one cycle earlier, so compare against the delayed expectation
        cmp_en_d  = (state_q == READ);
        cmp_exp_d = rexp_q;
        error_d   = error_q | (cmp_en_q && (rdata_0 != cmp_exp_q));
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    waddr_d = BASE;
                    wdata_d = INIT;
`ifdef WRITE_SEQ_READBACK_EN
                    error_d = 1'b0;
`endif
                    if (NUM_WORDS == 0) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end else begin
                        state_d = WRITE;
                        wen_d   = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (cnt_q == LAST) begin
`ifdef WRITE_SEQ_READBACK_EN
                    state_d = READ;
                    cnt_d   = '0;
                    raddr_d = BASE;
                    rexp_d  = INIT;
`else
                    state_d = DONE;
                    valid_d = 1'b1;
`endif
                end else begin
                    wen_d   = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    waddr_d = waddr_q + ADDR_W'(1);
                    wdata_d = wdata_q + INCR;
                end
            end
`ifdef WRITE_SEQ_READBACK_EN
            READ: begin
                if (cnt_q == LAST) begin
                    state_d = CHECK;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    raddr_d = raddr_q + ADDR_W'(1);
                    rexp_d  = rexp_q + INCR;
                end
            end
            CHECK: begin
                state_d = DONE;
                valid_d = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign waddr_0 = waddr_q;
    assign wdata_0 = wdata_q;
    assign wen_0   = wen_q;
    assign valid   = valid_q;

`ifdef WRITE_SEQ_READBACK_EN
    assign raddr_0 = raddr_q;
    assign error   = error_q;
`else
    assign raddr_0 = '0;
    assign error   = 1'b0;
    logic unused_rdata;
    assign unused_rdata = ^rdata_0;
`endif

endmodule

// File: tb/tb_write_seq.sv
// Scoreboard bench for write_seq: default, wrapping and zero-length instances, each with a small RAM model.
module tb_write_seq;

`ifdef WRITE_SEQ_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int LAT4 = (RB != 0) ? 10 : 5;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk, rst;
    logic start_a, start_b, start_c;
    logic valid_a, valid_b, valid_c;
    logic error_a, error_b, error_c;
    logic [4:0]  waddr_a, waddr_b, waddr_c, raddr_a, raddr_b, raddr_c;
    logic [31:0] wdata_a, wdata_b, wdata_c, rdata_a, rdata_b, rdata_c;
    logic wen_a, wen_b, wen_c;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_c_cnt = 0;
    wr_t q_a[$];
    wr_t q_b[$];
    wr_t e_a, e_b;

    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    int          corrupt_a = -1;
    logic        poke_en = 1'b0;
    logic [4:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;

    write_seq u_dut (
        .clk(clk), .rst(rst), .start(start_a), .valid(valid_a), .error(error_a),
        .waddr_0(waddr_a), .wdata_0(wdata_a), .wen_0(wen_a), .raddr_0(raddr_a), .rdata_0(rdata_a)
    );

    write_seq #(.BASE_ADDR(30), .NUM_WORDS(4), .INIT_VALUE(34), .STEP(2)) u_wrap (
        .clk(clk), .rst(rst), .start(start_b), .valid(valid_b), .error(error_b),
        .waddr_0(waddr_b), .wdata_0(wdata_b), .wen_0(wen_b), .raddr_0(raddr_b), .rdata_0(rdata_b)
    );

    write_seq #(.NUM_WORDS(0)) u_zero (
        .clk(clk), .rst(rst), .start(start_c), .valid(valid_c), .error(error_c),
        .waddr_0(waddr_c), .wdata_0(wdata_c), .wen_0(wen_c), .raddr_0(raddr_c), .rdata_0(rdata_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: synchronous write, registered read; instance a can corrupt one read address
    always @(posedge clk) begin
        if (poke_en)    mem_a[poke_addr] <= poke_data;
        else if (wen_a) mem_a[waddr_a] <= wdata_a;
        rdata_a <= (int'(raddr_a) == corrupt_a) ? 32'd99 : mem_a[raddr_a];
        if (wen_b) mem_b[waddr_b] <= wdata_b;
        rdata_b <= mem_b[raddr_b];
    end
    assign rdata_c = '0;

    // Monitors: every write pulse pops and checks the next expected write
    always @(negedge clk) begin
        if (wen_a) begin
            n_checks++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL wr_a_unexpected: got addr %0d data %0d, no write expected", waddr_a, wdata_a);
            end else begin
                e_a = q_a.pop_front();
                if (waddr_a !== e_a.a || wdata_a !== e_a.d) begin
                    n_fail++;
                    $display("FAIL wr_a: got addr %0d data %0d, want addr %0d data %0d",
                             waddr_a, wdata_a, e_a.a, e_a.d);
                end
            end
        end
        if (wen_b) begin
            n_checks++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL wr_b_unexpected: got addr %0d data %0d, no write expected", waddr_b, wdata_b);
            end else begin
                e_b = q_b.pop_front();
                if (waddr_b !== e_b.a || wdata_b !== e_b.d) begin
                    n_fail++;
                    $display("FAIL wr_b: got addr %0d data %0d, want addr %0d data %0d",
                             waddr_b, wdata_b, e_b.a, e_b.d);
                end
            end
        end
        if (wen_c) wr_c_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        case (which)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    function automatic logic valid_of(input int which);
        case (which)
            0: return valid_a;
            1: return valid_b;
            default: return valid_c;
        endcase
    endfunction

    function automatic logic error_of(input int which);
        case (which)
            0: return error_a;
            1: return error_b;
            default: return error_c;
        endcase
    endfunction

    // Start edge counts as cycle 1; returns valid/error seen just after the start edge
    task automatic run(input int which, input int exp_cycles, input string name, input bit hold,
                       output logic v0, output logic e0);
        int cycles;
        @(negedge clk);
        set_start(which, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) set_start(which, 1'b0);
        v0 = valid_of(which);
        e0 = error_of(which);
        cycles = 1;
        while (!valid_of(which) && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (hold) set_start(which, 1'b0);
        chk(name, 32'(cycles), 32'(exp_cycles));
    endtask

    task automatic poke(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic push_a4();
        for (int i = 0; i < 4; i++) q_a.push_back('{a: 5'(i), d: 32'(i)});
    endtask

    logic v0, e0;

    initial begin
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_error", 32'(error_a), 0);
        chk("rst_wen",   32'(wen_a), 0);
        chk("rst_waddr", 32'(waddr_a), 0);
        chk("rst_wdata", wdata_a, 0);
        chk("rst_raddr", 32'(raddr_a), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Default sequence 0,1,2,3 to addresses 0..3
        push_a4();
        run(0, LAT4, "lat_default", 1'b0, v0, e0);
        chk("default_error", 32'(error_a), 0);
        chk("default_drained", 32'(q_a.size()), 0);
        chk("default_mem3", mem_a[3], 3);
        repeat (2) @(posedge clk);
        #1 chk("valid_held", 32'(valid_a), 1);

        // Address wrap with stepped data
        q_b.push_back('{a: 5'd30, d: 32'd34});
        q_b.push_back('{a: 5'd31, d: 32'd36});
        q_b.push_back('{a: 5'd0,  d: 32'd38});
        q_b.push_back('{a: 5'd1,  d: 32'd40});
        run(1, LAT4, "lat_wrap", 1'b0, v0, e0);
        chk("wrap_error", 32'(error_b), 0);
        chk("wrap_drained", 32'(q_b.size()), 0);
        chk("wrap_mem0", mem_b[0], 38);
        chk("wrap_mem1", mem_b[1], 40);

        // Corrupted readback of address 2, then a clean rerun from DONE
        corrupt_a = 2;
        push_a4();
        run(0, LAT4, "lat_corrupt", 1'b0, v0, e0);
        chk("restart_clears_valid", 32'(v0), 0);
        chk("corrupt_error", 32'(error_a), 32'(RB));
        corrupt_a = -1;
        push_a4();
        run(0, LAT4, "lat_clean", 1'b0, v0, e0);
        chk("restart_clears_error", 32'(e0), 0);
        chk("clean_error", 32'(error_a), 0);
        chk("clean_drained", 32'(q_a.size()), 0);

        // Reset during the second write cycle
        poke(5'd1, 32'hDEAD);
        q_a.push_back('{a: 5'd0, d: 32'd0});
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_wen", 32'(wen_a), 0);
        chk("midrst_valid", 32'(valid_a), 0);
        chk("midrst_waddr", 32'(waddr_a), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_mem1", mem_a[1], 32'hDEAD);
        chk("midrst_mem0", mem_a[0], 0);
        chk("midrst_drained", 32'(q_a.size()), 0);
        chk("midrst_idle_valid", 32'(valid_a), 0);
        push_a4();
        run(0, LAT4, "lat_after_rst", 1'b0, v0, e0);
        chk("after_rst_error", 32'(error_a), 0);
        chk("after_rst_drained", 32'(q_a.size()), 0);

        // Start held high for the whole run: exactly one run of four writes
        push_a4();
        run(0, LAT4, "lat_held", 1'b1, v0, e0);
        chk("held_drained", 32'(q_a.size()), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("held_valid_stays", 32'(valid_a), 1);
        chk("held_no_rewrite", 32'(wen_a), 0);

        // Zero-length run
        run(2, 1, "lat_zero", 1'b0, v0, e0);
        chk("zero_error", 32'(error_c), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("zero_valid_held", 32'(valid_c), 1);
        chk("zero_no_writes", 32'(wr_c_cnt), 0);
        chk("zero_raddr", 32'(raddr_c), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/write_seq.md
WRITE_SEQ -- requirements
Module: write_seq

Interface
REQ-001 Parameter ADDR_W, default 5, width of RAM address ports.
REQ-002 Parameter DATA_W, default 32, width of RAM data ports.
REQ-003 Parameter BASE_ADDR, default 0, first address written.
REQ-004 Parameter NUM_WORDS, default 4, number of words written per run (0..2^ADDR_W).
REQ-005 Parameter INIT_VALUE, default 0, data written to BASE_ADDR.
REQ-006 Parameter STEP, default 1, data increment between consecutive words.
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  run request, sampled on rising clk.
REQ-010 valid  output  1  run complete; held until next accepted start.
REQ-011 error  output  1  sticky readback mismatch flag.
REQ-012 waddr_0  output  ADDR_W  RAM write address.
REQ-013 wdata_0  output  DATA_W  RAM write data.
REQ-014 wen_0  output  1  RAM write enable, one word per cycle when high.
REQ-015 raddr_0  output  ADDR_W  RAM read address.
REQ-016 rdata_0  input  DATA_W  RAM read data, valid one cycle after raddr_0 is presented.

Function
REQ-017 FSM states SHALL be IDLE, WRITE, READ, CHECK, DONE; all outputs driven from registers.
REQ-018 IDLE: start=1 at an edge SHALL move to WRITE at that edge, with addr counter=BASE_ADDR, data=INIT_VALUE, word count=0.
REQ-019 WRITE: wen_0=1 for exactly NUM_WORDS consecutive cycles; word i SHALL carry waddr_0=(BASE_ADDR+i) mod 2^ADDR_W, wdata_0=(INIT_VALUE+i*STEP) mod 2^DATA_W.
REQ-020 Address wrap past 2^ADDR_W-1 SHALL continue at 0 without error.
REQ-021 After the last write the FSM SHALL enter READ (readback compiled in) or DONE (compiled out) at the next edge.
REQ-022 NUM_WORDS=0: start SHALL go directly to DONE, no wen_0 pulse, no reads.
REQ-023 READ: raddr_0 SHALL step through the same NUM_WORDS addresses, one per cycle; each rdata_0 is compared one cycle later with the expected value.
REQ-024 CHECK: one extra cycle comparing the final word, then DONE.
REQ-025 Any mismatch SHALL set error at the edge after the compare; error stays set until the next accepted start or reset.
REQ-026 DONE: valid=1, wen_0=0; start=1 SHALL clear valid and error and begin a new run exactly as from IDLE.
REQ-027 start while in WRITE, READ or CHECK SHALL be ignored.
REQ-028 Latency start-edge to valid=1 SHALL be NUM_WORDS+1 cycles without readback, 2*NUM_WORDS+2 with readback.

Reset
REQ-029 rst=0 SHALL immediately force state IDLE, valid=0, error=0, wen_0=0, waddr_0=0, wdata_0=0, raddr_0=0, regardless of clk.
REQ-030 Reset mid-run SHALL abort with no further write; the next run requires a new start after rst=1.

Configuration
REQ-031 Macro WRITE_SEQ_READBACK_EN defined: READ and CHECK states present, error functional per REQ-023..025.
REQ-032 Macro WRITE_SEQ_READBACK_EN undefined: READ/CHECK removed, raddr_0 held 0, error tied 0, ports unchanged.

Verification
REQ-033 Reset, start pulse, defaults -> writes 0,1,2,3 to addresses 0..3 on consecutive cycles; valid=1 five cycles after start (no readback) or ten (readback); RAM debug read of address 3 = 3.
REQ-034 BASE_ADDR=30, NUM_WORDS=4, INIT_VALUE=34, STEP=2 -> addresses 30,31,0,1 receive 34,36,38,40; error=0.
REQ-035 Readback build, bench RAM corrupts address 2 read to 99 -> error=1 with valid=1; next start clears both.
REQ-036 rst=0 asserted during the second write cycle -> wen_0 drops asynchronously, valid=0; address 1 contents unchanged; new start completes normally.
REQ-037 start held high throughout run -> single run only; restart occurs only from DONE; NUM_WORDS=0 -> valid=1 one cycle after start, wen_0 never high.
